// File: rtl/gamma_pkg.sv
// Shared constants and bank-index type for the banked gamma lookup.
package gamma_pkg;

    localparam int IN_W_DEF  = 8;
    localparam int OUT_W_DEF = 12;
    localparam int CH_DEF    = 3;

    typedef enum logic {
        BANK_0 = 1'b0,
        BANK_1 = 1'b1
    } bank_t;

    function automatic bank_t otherBank(input bank_t b);
        return (b == BANK_0) ? BANK_1 : BANK_0;
    endfunction

endpackage

// File: rtl/gamma_lut_ram.sv
// One-write / one-registered-read table, one copy per channel per bank.
module gamma_lut_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 12
) (
    input  logic              clk_i,
    input  logic              wrEn_i,
    input  logic [ADDR_W-1:0] wrAddr_i,
    input  logic [DATA_W-1:0] wrData_i,
    input  logic [ADDR_W-1:0] rdAddr_i,
    output logic [DATA_W-1:0] rdData_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdData_q;

    // Contents are intentionally never reset; the read returns pre-write data.
    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
        rdData_q <= mem_q[rdAddr_i];
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/gamma_lut_banked.sv
// Double-banked per-channel gamma LUT with frame-aligned bank swap and bypass.
module gamma_lut_banked
    import gamma_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int CH    = CH_DEF
) (
    input  logic                I_clk,
    input  logic                I_rst,
    input  logic                I_vs,
    input  logic                I_valid,
    input  logic [CH*IN_W-1:0]  I_data,
    input  logic                I_bypass,
    input  logic                I_wr_en,
    input  logic [IN_W-1:0]     I_wr_addr,
    input  logic [OUT_W-1:0]    I_wr_data,
    input  logic                I_swap_req,
    output logic                O_wr_ready,
    output logic                O_swap_pend,
    output logic                O_bank,
    output logic                O_vs,
    output logic                O_valid,
    output logic [CH*OUT_W-1:0] O_data
);

    bank_t                bank_q, bank_d;
    logic                 swapPend_q, swapPend_d;
    logic                 bypass_q, bypass_d;
    logic                 swapNow;
    logic                 wrAccept;
    logic [1:0]           wrEnBank;

    logic                 valid1_q, vs1_q, bypass1_q;
    bank_t                sel1_q;
    logic [CH*IN_W-1:0]   data1_q;

    logic                 valid2_q, vs2_q;
    logic [CH*OUT_W-1:0]  data2_q, data2_d;

    logic [OUT_W-1:0]     rdData [2][CH];

    // Swap and bypass latch take effect on the I_vs pixel itself, so the
    // stage-1 bank/mode registers capture the next-state values.
    always_comb begin
        swapNow     = I_vs && (swapPend_q || I_swap_req);
        bank_d      = swapNow ? otherBank(bank_q) : bank_q;
        swapPend_d  = swapNow ? 1'b0 : (swapPend_q || I_swap_req);
        bypass_d    = I_vs ? I_bypass : bypass_q;
        wrAccept    = I_wr_en && !swapPend_q && !I_rst;
        wrEnBank[0] = wrAccept && (bank_q == BANK_1);
        wrEnBank[1] = wrAccept && (bank_q == BANK_0);
    end

    for (genvar b = 0; b < 2; b++) begin : gBank
        for (genvar c = 0; c < CH; c++) begin : gCh
            gamma_lut_ram #(
                .ADDR_W (IN_W),
                .DATA_W (OUT_W)
            ) uRam (
                .clk_i    (I_clk),
                .wrEn_i   (wrEnBank[b]),
                .wrAddr_i (I_wr_addr),
                .wrData_i (I_wr_data),
                .rdAddr_i (I_data[c*IN_W +: IN_W]),
                .rdData_o (rdData[b][c])
            );
        end
    end

    always_comb begin
        data2_d = '0;
        for (int c = 0; c < CH; c++) begin
            if (valid1_q) begin
                if (bypass1_q) begin
                    data2_d[c*OUT_W +: OUT_W] = OUT_W'(data1_q[c*IN_W +: IN_W]) << (OUT_W - IN_W);
                end else begin
                    data2_d[c*OUT_W +: OUT_W] = (sel1_q == BANK_1) ? rdData[1][c] : rdData[0][c];
                end
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            bank_q     <= BANK_0;
            swapPend_q <= 1'b0;
            bypass_q   <= 1'b1;
            valid1_q   <= 1'b0;
            vs1_q      <= 1'b0;
            bypass1_q  <= 1'b1;
            sel1_q     <= BANK_0;
            data1_q    <= '0;
            valid2_q   <= 1'b0;
            vs2_q      <= 1'b0;
            data2_q    <= '0;
        end else begin
            bank_q     <= bank_d;
            swapPend_q <= swapPend_d;
            bypass_q   <= bypass_d;
            valid1_q   <= I_valid;
            vs1_q      <= I_vs;
            bypass1_q  <= bypass_d;
            sel1_q     <= bank_d;
            data1_q    <= I_data;
            valid2_q   <= valid1_q;
            vs2_q      <= vs1_q;
            data2_q    <= data2_d;
        end
    end

    assign O_wr_ready  = !swapPend_q;
    assign O_swap_pend = swapPend_q;
    assign O_bank      = bank_q;
    assign O_vs        = vs2_q;
    assign O_valid     = valid2_q;
    assign O_data      = data2_q;

endmodule

// File: tb/tb_gamma_lut_banked.sv
// Directed, table-driven bench for gamma_lut_banked (IN_W=8, OUT_W=12, CH=3).
module tb_gamma_lut_banked;

    logic        I_clk = 1'b0;
    logic        I_rst;
    logic        I_vs;
    logic        I_valid;
    logic [23:0] I_data;
    logic        I_bypass;
    logic        I_wr_en;
    logic [7:0]  I_wr_addr;
    logic [11:0] I_wr_data;
    logic        I_swap_req;
    logic        O_wr_ready;
    logic        O_swap_pend;
    logic        O_bank;
    logic        O_vs;
    logic        O_valid;
    logic [35:0] O_data;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic        vs;
        logic        valid;
        logic [23:0] data;
        logic [35:0] expData;
    } vec_t;

    vec_t vecs[5];

    always #5 I_clk = ~I_clk;

    gamma_lut_banked #(
        .IN_W  (8),
        .OUT_W (12),
        .CH    (3)
    ) dut (
        .I_clk       (I_clk),
        .I_rst       (I_rst),
        .I_vs        (I_vs),
        .I_valid     (I_valid),
        .I_data      (I_data),
        .I_bypass    (I_bypass),
        .I_wr_en     (I_wr_en),
        .I_wr_addr   (I_wr_addr),
        .I_wr_data   (I_wr_data),
        .I_swap_req  (I_swap_req),
        .O_wr_ready  (O_wr_ready),
        .O_swap_pend (O_swap_pend),
        .O_bank      (O_bank),
        .O_vs        (O_vs),
        .O_valid     (O_valid),
        .O_data      (O_data)
    );

    function automatic logic [35:0] rep3(input logic [11:0] v);
        return {v, v, v};
    endfunction

    task automatic step();
        @(posedge I_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic vs, input logic valid, input logic [23:0] data, input logic bypass);
        I_vs     = vs;
        I_valid  = valid;
        I_data   = data;
        I_bypass = bypass;
        step();
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, {8'd16, 8'd16, 8'd16},   rep3(12'd261)};
        vecs[1] = '{1'b0, 1'b1, {8'd255, 8'd128, 8'd0},  {12'd4085, 12'd2053, 12'd5}};
        vecs[2] = '{1'b0, 1'b1, {8'd3, 8'd2, 8'd1},      {12'd53, 12'd37, 12'd21}};
        vecs[3] = '{1'b0, 1'b0, {8'd7, 8'd7, 8'd7},      36'd0};
        vecs[4] = '{1'b0, 1'b1, {8'd128, 8'd0, 8'd255},  {12'd2053, 12'd5, 12'd4085}};

        I_rst = 1'b1; I_vs = 1'b0; I_valid = 1'b0; I_data = '0; I_bypass = 1'b0;
        I_wr_en = 1'b0; I_wr_addr = '0; I_wr_data = '0; I_swap_req = 1'b0;
        step();
        step();
        checkOutput("rst_bank",     O_bank,      0);
        checkOutput("rst_pend",     O_swap_pend, 0);
        checkOutput("rst_wr_ready", O_wr_ready,  1);
        checkOutput("rst_valid",    O_valid,     0);
        checkOutput("rst_vs",       O_vs,        0);
        checkOutput("rst_data",     O_data,      0);
        I_rst = 1'b0;

        // Bypass frame straight out of reset
        applyStimulus(1'b1, 1'b1, {3{8'hFF}}, 1'b1);
        applyStimulus(1'b0, 1'b0, 24'd0, 1'b1);
        checkOutput("byp_valid", O_valid, 1);
        checkOutput("byp_vs",    O_vs,    1);
        checkOutput("byp_data",  O_data,  rep3(12'hFF0));
        applyStimulus(1'b0, 1'b0, 24'd0, 1'b1);
        checkOutput("idle_valid", O_valid, 0);
        checkOutput("idle_data",  O_data,  0);

        // Ramp into shadow bank 1
        for (int a = 0; a < 256; a++) begin
            I_wr_en   = 1'b1;
            I_wr_addr = a[7:0];
            I_wr_data = 12'(a * 16 + 5);
            step();
        end
        I_wr_en = 1'b0;
        I_swap_req = 1'b1;
        step();
        I_swap_req = 1'b0;
        checkOutput("arm_pend",     O_swap_pend, 1);
        checkOutput("arm_wr_ready", O_wr_ready,  0);
        checkOutput("arm_bank",     O_bank,      0);

        for (int i = 0; i <= 5; i++) begin
            if (i < 5) applyStimulus(vecs[i].vs, vecs[i].valid, vecs[i].data, 1'b0);
            else       applyStimulus(1'b0, 1'b0, 24'd0, 1'b0);
            if (i == 0) begin
                checkOutput("swap_bank", O_bank,      1);
                checkOutput("swap_pend", O_swap_pend, 0);
            end else begin
                checkOutput($sformatf("vec%0d_valid", i-1), O_valid, vecs[i-1].valid);
                checkOutput($sformatf("vec%0d_vs", i-1),    O_vs,    vecs[i-1].vs);
                checkOutput($sformatf("vec%0d_data", i-1),  O_data,  vecs[i-1].expData);
            end
        end

        // Mid-frame writes to shadow bank 0, then a pending swap drops writes
        I_wr_en = 1'b1; I_wr_addr = 8'd16;  I_wr_data = 12'd100;
        applyStimulus(1'b0, 1'b1, {3{8'd16}}, 1'b0);
        I_wr_addr = 8'd200; I_wr_data = 12'd300;
        applyStimulus(1'b0, 1'b1, {3{8'd16}}, 1'b0);
        I_wr_en = 1'b0;
        applyStimulus(1'b0, 1'b1, {3{8'd16}}, 1'b0);
        checkOutput("shadow_hidden", O_data, rep3(12'd261));
        I_swap_req = 1'b1;
        applyStimulus(1'b0, 1'b1, {3{8'd16}}, 1'b0);
        I_swap_req = 1'b0;
        checkOutput("mid_pend", O_swap_pend, 1);
        I_wr_en = 1'b1; I_wr_addr = 8'd16; I_wr_data = 12'd999;
        applyStimulus(1'b0, 1'b1, {3{8'd16}}, 1'b0);
        I_wr_en = 1'b0;
        applyStimulus(1'b0, 1'b1, {3{8'd16}}, 1'b0);
        checkOutput("pend_bank", O_bank, 1);
        checkOutput("pend_data", O_data, rep3(12'd261));
        applyStimulus(1'b1, 1'b1, {8'd16, 8'd200, 8'd16}, 1'b0);
        checkOutput("mid_swap_bank", O_bank,      0);
        checkOutput("mid_swap_pend", O_swap_pend, 0);
        applyStimulus(1'b0, 1'b0, 24'd0, 1'b0);
        checkOutput("readback_vs",   O_vs,   1);
        checkOutput("readback_data", O_data, {12'd100, 12'd300, 12'd100});

        // Swap request coincident with I_vs
        I_swap_req = 1'b1;
        applyStimulus(1'b1, 1'b1, {3{8'd16}}, 1'b0);
        I_swap_req = 1'b0;
        checkOutput("coin_bank",     O_bank,      1);
        checkOutput("coin_pend",     O_swap_pend, 0);
        checkOutput("coin_wr_ready", O_wr_ready,  1);
        applyStimulus(1'b0, 1'b1, {3{8'd16}}, 1'b1);
        checkOutput("coin_vs",   O_vs,   1);
        checkOutput("coin_data", O_data, rep3(12'd261));
        applyStimulus(1'b0, 1'b1, {3{8'd16}}, 1'b1);
        checkOutput("bypass_hold_vs",   O_vs,   0);
        checkOutput("bypass_hold_data", O_data, rep3(12'd261));

        // Reset mid-frame with a swap armed
        I_swap_req = 1'b1;
        applyStimulus(1'b0, 1'b1, {3{8'd16}}, 1'b0);
        I_swap_req = 1'b0;
        checkOutput("prerst_pend", O_swap_pend, 1);
        I_rst = 1'b1;
        applyStimulus(1'b0, 1'b1, {3{8'd16}}, 1'b0);
        I_rst = 1'b0;
        checkOutput("mrst_bank",  O_bank,      0);
        checkOutput("mrst_pend",  O_swap_pend, 0);
        checkOutput("mrst_valid", O_valid,     0);
        checkOutput("mrst_data",  O_data,      0);
        applyStimulus(1'b0, 1'b0, 24'd0, 1'b0);
        checkOutput("mrst_stage1_clear", O_valid, 0);
        applyStimulus(1'b0, 1'b1, {8'd3, 8'd2, 8'd1}, 1'b0);
        applyStimulus(1'b0, 1'b0, 24'd0, 1'b0);
        checkOutput("mrst_default_bypass", O_data, {12'h030, 12'h020, 12'h010});
        applyStimulus(1'b1, 1'b1, {8'hEF, 8'hCD, 8'hAB}, 1'b1);
        applyStimulus(1'b0, 1'b0, 24'd0, 1'b0);
        checkOutput("newframe_valid", O_valid, 1);
        checkOutput("newframe_data",  O_data,  {12'hEF0, 12'hCD0, 12'hAB0});

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/gamma_lut_banked.md
GAMMA_LUT_BANKED -- requirements
Module: gamma_lut_banked

Interface
REQ-001 SHALL have parameter IN_W, default 8: input sample width per channel; table depth is 2**IN_W.
REQ-002 SHALL have parameter OUT_W, default 12: output sample width per channel; OUT_W >= IN_W.
REQ-003 SHALL have parameter CH, default 3: number of parallel colour channels sharing one table.
REQ-004 SHALL have the port I_clk, input, 1 bit: the single clock.
REQ-005 SHALL have the port I_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have the port I_vs, input, 1 bit: one-cycle frame-start pulse.
REQ-007 SHALL have the port I_valid, input, 1 bit: pixel qualifier.
REQ-008 SHALL have the port I_data, input, CH*IN_W bits: channel 0 in the LSBs.
REQ-009 SHALL have the port I_bypass, input, 1 bit: bypass request, sampled only at I_vs.
REQ-010 SHALL have the port I_wr_en, input, 1 bit: table write strobe.
REQ-011 SHALL have the port I_wr_addr, input, IN_W bits: table write address.
REQ-012 SHALL have the port I_wr_data, input, OUT_W bits: table write data.
REQ-013 SHALL have the port I_swap_req, input, 1 bit: request to make the shadow bank active.
REQ-014 SHALL have the port O_wr_ready, output, 1 bit: high when writes are accepted.
REQ-015 SHALL have the port O_swap_pend, output, 1 bit: a swap is armed.
REQ-016 SHALL have the port O_bank, output, 1 bit: index of the active bank.
REQ-017 SHALL have the port O_vs, output, 1 bit: I_vs delayed to align with O_data.
REQ-018 SHALL have the port O_valid, output, 1 bit: I_valid delayed to align with O_data.
REQ-019 SHALL have the port O_data, output, CH*OUT_W bits: mapped pixel.

Function
REQ-020 SHALL hold two table banks; the active bank is read, the other (shadow) is written.
REQ-021 SHALL have a fixed latency of 2 cycles from I_data/I_valid/I_vs to O_data/O_valid/O_vs, with no stall and no backpressure.
REQ-022 SHALL map each channel c as O_data[c] = active_bank[I_data[c]]; all CH lookups occur in the same cycle.
REQ-023 SHALL, in bypass, output I_data[c] shifted left by (OUT_W-IN_W) with zero-filled LSBs, at the same 2-cycle latency.
REQ-024 SHALL latch the bypass mode from I_bypass only on an I_vs cycle, so the mode is constant for a whole frame.
REQ-025 SHALL drive O_data to 0 when O_valid=0.
REQ-026 SHALL, when I_wr_en=1 and O_wr_ready=1, write I_wr_data to shadow_bank[I_wr_addr], visible to reads only after a swap.
REQ-027 SHALL ignore writes when O_wr_ready=0; O_wr_ready = !O_swap_pend.
REQ-028 SHALL set O_swap_pend on I_swap_req=1 and hold it until the swap.
REQ-029 SHALL perform the swap on the next I_vs while pending: toggle O_bank and clear O_swap_pend in that cycle.
REQ-030 SHALL make a swap apply starting with the pixel presented in the I_vs cycle, and never apply a swap mid-frame.
REQ-031 SHALL, when I_swap_req and I_vs coincide, swap in that same cycle; O_swap_pend then never rises.
REQ-032 SHALL ignore I_swap_req while O_swap_pend=1, with no queuing.
REQ-033 SHALL apply a bank swap and a bypass-mode change to the same I_vs pixel.

Reset
REQ-034 SHALL, on I_rst=1 at a clock edge, set O_bank=0, O_swap_pend=0, the latched bypass mode=1, O_valid=0, O_vs=0 and O_data=0, and clear both pipeline stages.
REQ-035 SHALL not initialise table contents on reset; bypass=1 is the default so that no undefined data reaches the output.
REQ-036 SHALL discard in-flight pixels and any armed swap when reset is asserted mid-frame; a write in the reset cycle is ignored.

Structure
REQ-037 SHALL take the default IN_W/OUT_W/CH constants and the bank-index type from a shared package, gamma_pkg.
REQ-038 SHALL be built from sub-module gamma_lut_ram (1 write / 1 registered read, depth 2**IN_W x OUT_W), instantiated 2 banks x CH copies; all copies in a bank are written identically.

Verification
REQ-039 SHALL pass this scenario: reset, then I_vs with I_bypass=1 and pixel 8'hFF on all channels -> 2 cycles later O_valid=1 and each channel = 12'hFF0.
REQ-040 SHALL pass this scenario: write a ramp shadow[a]=a*16+5, swap_req, then I_vs with bypass=0 and pixel 8'h10 -> O_bank=1 and each channel = 12'd261.
REQ-041 SHALL pass this scenario: swap_req mid-frame -> O_swap_pend=1 and output unchanged until next I_vs; writes during pend are dropped and a readback after the swap confirms the old value.
REQ-042 SHALL pass this scenario: I_swap_req and I_vs in the same cycle -> O_bank toggles that cycle and O_swap_pend stays 0.
REQ-043 SHALL pass this scenario: I_rst for 1 cycle mid-frame with O_swap_pend=1 -> O_bank=0, pend=0, O_valid=0 within 1 cycle, then bypass output on the next frame.
REQ-044 SHALL pass this scenario: CH=3, pixels {8'd0, 8'd128, 8'd255} through a loaded table -> each channel independently equals its table entry, and O_vs aligns with the first pixel.
